// File: rtl/video_pkg.sv
// Shared video-path definitions: framer FSM states and the luma-stage latency.
package video_pkg;

    // Geometry tracker states: hunt for a frame start, measure a frame, then police it.
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } framer_state_t;

    // Pipeline depth of the RGB-to-luma stage; the framer matches it so that
    // sync and data stay aligned end to end.
    localparam int LUMA_LATENCY = 2;

endpackage

// File: rtl/edge_detect.sv
// Single-bit edge detector: remembers the previous sample and flags rise/fall.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_d;

    // Previous-cycle copy of the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d <= 1'b0;
        end else begin
            r_d <= i_d;
        end
    end

    assign o_rise = i_d & ~r_d;
    assign o_fall = ~i_d & r_d;

endmodule

// File: rtl/y_stream_framer.sv
// Luma stream sink: gray RGB expansion, pixel/line coordinates, frame geometry
// measurement and lock, with a single-cycle error pulse on geometry violations.
// Stage 1 registers the inputs and their edges; stage 2 drives every output.
module y_stream_framer
    import video_pkg::*;
#(
    parameter int COLORDEPTH = 8,
    parameter int XW         = 11,
    parameter int YW         = 11
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [COLORDEPTH-1:0]   y_i,
    input  logic                    dv_i,
    input  logic                    hs_i,
    input  logic                    vs_i,
    output logic [3*COLORDEPTH-1:0] rgb_o,
    output logic                    dv_o,
    output logic                    hs_o,
    output logic                    vs_o,
    output logic [XW-1:0]           x_o,
    output logic [YW-1:0]           y_o,
    output logic [XW-1:0]           h_active_o,
    output logic [YW-1:0]           v_active_o,
    output logic                    locked_o,
    output logic                    geom_err_o
);

    localparam logic [XW-1:0] X_MAX = '1;
    localparam logic [YW-1:0] Y_MAX = '1;

    // ---------------- edge detection ----------------
    logic w_dv_rise, w_dv_fall, w_vs_rise, w_vs_fall;
    logic w_unused;

    edge_detect u_dv_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (dv_i),
        .o_rise (w_dv_rise),
        .o_fall (w_dv_fall)
    );

    edge_detect u_vs_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (vs_i),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    // The end of vsync carries no framing information.
    assign w_unused = &{1'b0, w_vs_fall};

    // ---------------- stage 1 ----------------
    logic [COLORDEPTH-1:0] r_s1_y;
    logic r_s1_dv, r_s1_hs, r_s1_vs;
    logic r_s1_dv_rise, r_s1_dv_fall, r_s1_vs_rise;

    // Capture inputs together with their edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_y       <= '0;
            r_s1_dv      <= 1'b0;
            r_s1_hs      <= 1'b0;
            r_s1_vs      <= 1'b0;
            r_s1_dv_rise <= 1'b0;
            r_s1_dv_fall <= 1'b0;
            r_s1_vs_rise <= 1'b0;
        end else begin
            r_s1_y       <= y_i;
            r_s1_dv      <= dv_i;
            r_s1_hs      <= hs_i;
            r_s1_vs      <= vs_i;
            r_s1_dv_rise <= w_dv_rise;
            r_s1_dv_fall <= w_dv_fall;
            r_s1_vs_rise <= w_vs_rise;
        end
    end

    // ---------------- pixel / line counters ----------------
    // r_xcnt holds the number of pixels seen so far in the current line, which is
    // also the index of the next pixel; at a dv fall it is the finished line length.
    logic [XW-1:0] r_xcnt;
    logic [YW-1:0] r_ycnt;
    logic          r_sat_seen;
    logic [XW-1:0] w_x_base;
    logic [YW-1:0] w_y_base;
    logic          w_sat_base;
    logic          w_sat_hit;
    logic [XW-1:0] w_line_len;
    logic [YW-1:0] w_frame_lines;

    assign w_x_base   = r_s1_dv_rise ? '0 : r_xcnt;
    assign w_sat_base = r_s1_dv_rise ? 1'b0 : r_sat_seen;
    assign w_sat_hit  = r_s1_dv & (w_x_base == X_MAX) & ~w_sat_base;
    assign w_y_base   = r_s1_vs_rise ? '0 : r_ycnt;
    assign w_line_len = r_xcnt;
    // A line ending in the same cycle as the frame start belongs to the ending frame.
    assign w_frame_lines = (r_s1_dv_fall && (r_ycnt != Y_MAX)) ? r_ycnt + YW'(1) : r_ycnt;

    // Saturating pixel counter per line and line counter per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xcnt     <= '0;
            r_ycnt     <= '0;
            r_sat_seen <= 1'b0;
        end else begin
            if (r_s1_dv) begin
                r_xcnt     <= (w_x_base == X_MAX) ? X_MAX : w_x_base + XW'(1);
                r_sat_seen <= w_sat_base | w_sat_hit;
            end
            if (r_s1_vs_rise) begin
                r_ycnt <= '0;
            end else if (r_s1_dv_fall && (r_ycnt != Y_MAX)) begin
                r_ycnt <= r_ycnt + YW'(1);
            end
        end
    end

    // ---------------- geometry FSM ----------------
    framer_state_t r_state, w_state_next;
    logic [XW-1:0] r_cand, w_cand_next;
    logic          r_cand_valid, w_cand_valid_next;
    logic [XW-1:0] r_h_active, w_h_active_next;
    logic [YW-1:0] r_v_active, w_v_active_next;
    logic          r_locked, w_locked_next;
    logic          w_fsm_err;

    // State and measured-geometry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SEARCH;
            r_cand       <= '0;
            r_cand_valid <= 1'b0;
            r_h_active   <= '0;
            r_v_active   <= '0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cand       <= w_cand_next;
            r_cand_valid <= w_cand_valid_next;
            r_h_active   <= w_h_active_next;
            r_v_active   <= w_v_active_next;
            r_locked     <= w_locked_next;
        end
    end

    // Next-state logic: line events are evaluated before the frame event of the same cycle.
    always_comb begin
        w_state_next      = r_state;
        w_cand_next       = r_cand;
        w_cand_valid_next = r_cand_valid;
        w_h_active_next   = r_h_active;
        w_v_active_next   = r_v_active;
        w_locked_next     = r_locked;
        w_fsm_err         = 1'b0;
        case (r_state)
            SEARCH: begin
                if (r_s1_vs_rise) begin
                    w_state_next      = MEASURE;
                    w_cand_valid_next = 1'b0;
                end
            end
            MEASURE: begin
                if (r_s1_dv_fall) begin
                    if (!r_cand_valid) begin
                        w_cand_next       = w_line_len;
                        w_cand_valid_next = 1'b1;
                    end else if (w_line_len != r_cand) begin
                        w_fsm_err = 1'b1;
                    end
                end
                if (w_fsm_err) begin
                    w_state_next      = SEARCH;
                    w_cand_valid_next = 1'b0;
                end else if (r_s1_vs_rise && (w_frame_lines != '0)) begin
                    w_state_next    = LOCKED;
                    w_h_active_next = w_cand_next;
                    w_v_active_next = w_frame_lines;
                    w_locked_next   = 1'b1;
                end
            end
            LOCKED: begin
                if (r_s1_dv_fall && (w_line_len != r_h_active)) begin
                    w_fsm_err = 1'b1;
                end
                if (r_s1_vs_rise && (w_frame_lines != r_v_active)) begin
                    w_fsm_err = 1'b1;
                end
                if (w_fsm_err) begin
                    w_state_next      = SEARCH;
                    w_locked_next     = 1'b0;
                    w_h_active_next   = '0;
                    w_v_active_next   = '0;
                    w_cand_valid_next = 1'b0;
                end
            end
            default: begin
                w_state_next = SEARCH;
            end
        endcase
    end

    // ---------------- stage 2 ----------------
    logic [3*COLORDEPTH-1:0] r_rgb;
    logic                    r_dv, r_hs, r_vs, r_geom_err;
    logic [XW-1:0]           r_x;
    logic [YW-1:0]           r_y;

    // Output registers; data and coordinates are blanked outside active video.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb      <= '0;
            r_dv       <= 1'b0;
            r_hs       <= 1'b0;
            r_vs       <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_geom_err <= 1'b0;
        end else begin
            r_rgb      <= r_s1_dv ? {3{r_s1_y}} : '0;
            r_dv       <= r_s1_dv;
            r_hs       <= r_s1_hs;
            r_vs       <= r_s1_vs;
            r_x        <= r_s1_dv ? w_x_base : '0;
            r_y        <= r_s1_dv ? w_y_base : '0;
            r_geom_err <= w_sat_hit | w_fsm_err;
        end
    end

    assign rgb_o      = r_rgb;
    assign dv_o       = r_dv;
    assign hs_o       = r_hs;
    assign vs_o       = r_vs;
    assign x_o        = r_x;
    assign y_o        = r_y;
    assign geom_err_o = r_geom_err;
    assign h_active_o = r_h_active;
    assign v_active_o = r_v_active;
    assign locked_o   = r_locked;

endmodule
